ysyx_25060173_idu: RTL and testbench

Instruction decode unit for the NPC core, sitting directly upstream of the ALU. It accepts a fetched instruction and PC from the IFU over a valid/ready handshake, reads rs1 through the register file read port, and decodes the instruction. It then registers `alu_src1`, `alu_src2`, `alu_op` and writeback control into a one-entry output stage for the EXU/ALU. It also owns the halt condition on `ebreak` or an illegal instruction.

---
 rtl/ysyx_25060173_pkg.sv | 33 +++
 rtl/ysyx_25060173_imm_gen.sv | 12 +
 rtl/ysyx_25060173_idu.sv | 138 +++++++++++++
 tb/tb_ysyx_25060173_idu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060173_pkg.sv
// rtl/ysyx_25060173_pkg.sv - shared opcode, alu_op and state definitions for the IDU
package ysyx_25060173_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    localparam logic [1:0] ALU_NONE  = 2'b00;
    localparam logic [1:0] ALU_ADDI  = 2'b01;
    localparam logic [1:0] ALU_AUIPC = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } idu_state_e;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [1:0]  op;
        logic        wen;
        logic        jump;
        logic        halt_req;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/ysyx_25060173_imm_gen.sv
// rtl/ysyx_25060173_imm_gen.sv - combinational I-type and U-type immediate extraction
module ysyx_25060173_imm_gen (
    input  logic [19:0] inst_hi,
    output logic [31:0] imm_i,
    output logic [31:0] imm_u
);

    // inst_hi carries inst[31:12]; the low bits hold no immediate data for these formats
    assign imm_i = {{20{inst_hi[19]}}, inst_hi[19:8]};
    assign imm_u = {inst_hi, 12'h000};

endmodule

// File: rtl/ysyx_25060173_idu.sv
// rtl/ysyx_25060173_idu.sv - instruction decode unit with one-entry output stage and halt FSM
module ysyx_25060173_idu
    import ysyx_25060173_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    input  logic [XLEN-1:0] rs1_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic [1:0]      alu_op,
    output logic [4:0]      rd,
    output logic            rf_wen,
    output logic            jump_valid,
    output logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] out_pc,
    output logic            halted,
    output logic            halt_illegal,
    output logic [31:0]     dec_count
);

    idu_state_e  state_q, state_d;
    dec_t        dec;
    logic [31:0] imm_i, imm_u;
    logic [31:0] target_d;
    logic        load;

    ysyx_25060173_imm_gen u_imm_gen (
        .inst_hi (in_inst[31:12]),
        .imm_i   (imm_i),
        .imm_u   (imm_u)
    );

    assign rs1_addr = in_inst[19:15];
    assign load     = in_valid && in_ready;

    always_comb begin
        dec = '0;
        case (in_inst[6:0])
            OP_IMM: begin
                if (in_inst[14:12] == F3_ADDI) begin
                    dec.op   = ALU_ADDI;
                    dec.src1 = rs1_data;
                    dec.src2 = imm_i;
                    dec.wen  = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_LUI: begin
                dec.op   = ALU_ADDI;
                dec.src2 = imm_u;
                dec.wen  = 1'b1;
            end
            OP_AUIPC: begin
                dec.op   = ALU_AUIPC;
                dec.src1 = in_pc;
                dec.src2 = imm_u;
                dec.wen  = 1'b1;
            end
            OP_JALR: begin
                if (in_inst[14:12] == F3_JALR) begin
                    dec.op   = ALU_ADDI;
                    dec.src1 = in_pc;
                    dec.src2 = 32'd4;
                    dec.wen  = 1'b1;
                    dec.jump = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = (in_inst != INST_EBREAK);
        endcase
        // ebreak falls into the default arm with illegal=0, so halt_req covers both
        dec.halt_req = dec.illegal || (in_inst == INST_EBREAK);
    end

    assign target_d = dec.jump ? ((rs1_data + imm_i) & ~32'h1) : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && load && dec.halt_req) begin
            state_d = HALT;
        end
    end

    always_comb begin
        in_ready = (state_q == RUN) && (!out_valid || out_ready);
        halted   = (state_q == HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            alu_src1     <= '0;
            alu_src2     <= '0;
            alu_op       <= ALU_NONE;
            rd           <= '0;
            rf_wen       <= 1'b0;
            jump_valid   <= 1'b0;
            jump_target  <= '0;
            out_pc       <= '0;
            halt_illegal <= 1'b0;
            dec_count    <= '0;
        end else if (load) begin
            out_valid    <= 1'b1;
            alu_src1     <= dec.src1;
            alu_src2     <= dec.src2;
            alu_op       <= dec.op;
            rd           <= in_inst[11:7];
            rf_wen       <= dec.wen && (in_inst[11:7] != 5'd0);
            jump_valid   <= dec.jump;
            jump_target  <= target_d;
            out_pc       <= in_pc;
            halt_illegal <= halt_illegal || dec.illegal;
            dec_count    <= dec_count + 32'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_25060173_idu.sv
// tb/tb_ysyx_25060173_idu.sv - self-checking bench for ysyx_25060173_idu
module tb_ysyx_25060173_idu;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, rs1_data, alu_src1, alu_src2, jump_target, out_pc, dec_count;
    logic [4:0]  rs1_addr, rd;
    logic [1:0]  alu_op;
    logic        rf_wen, jump_valid, halted, halt_illegal;

    always #5 clk = ~clk;

    ysyx_25060173_idu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_src1(alu_src1),
        .alu_src2(alu_src2), .alu_op(alu_op), .rd(rd), .rf_wen(rf_wen),
        .jump_valid(jump_valid), .jump_target(jump_target), .out_pc(out_pc),
        .halted(halted), .halt_illegal(halt_illegal), .dec_count(dec_count)
    );

    typedef struct packed {
        logic [31:0] src1, src2, jt, pc;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic        wen, jv, halt, ill;
    } exp_t;

    int   n_pass = 0, n_total = 0;
    logic model_live = 1'b0;
    logic m_valid, m_halted, m_ill;
    logic [31:0] m_cnt;
    exp_t m_b;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
    endtask

    function automatic exp_t model_decode(input logic [31:0] inst, input logic [31:0] pc,
                                          input logic [31:0] r1);
        exp_t e;
        logic [31:0] immi, immu;
        immi = {{20{inst[31]}}, inst[31:20]};
        immu = {inst[31:12], 12'h000};
        e = '0;
        e.rd = inst[11:7];
        e.pc = pc;
        if (inst == 32'h00100073) e.halt = 1'b1;
        else if (inst[6:0] == 7'h13 && inst[14:12] == 3'd0) begin
            e.op = 2'd1; e.src1 = r1; e.src2 = immi; e.wen = 1'b1;
        end else if (inst[6:0] == 7'h37) begin
            e.op = 2'd1; e.src1 = 32'd0; e.src2 = immu; e.wen = 1'b1;
        end else if (inst[6:0] == 7'h17) begin
            e.op = 2'd2; e.src1 = pc; e.src2 = immu; e.wen = 1'b1;
        end else if (inst[6:0] == 7'h67 && inst[14:12] == 3'd0) begin
            e.op = 2'd1; e.src1 = pc; e.src2 = 32'd4; e.wen = 1'b1;
            e.jv = 1'b1; e.jt = (r1 + immi) & 32'hFFFF_FFFE;
        end else begin
            e.halt = 1'b1; e.ill = 1'b1;
        end
        if (e.rd == 5'd0) e.wen = 1'b0;
        return e;
    endfunction

    // Reference model advances on the same edge the DUT samples on
    always @(posedge clk) begin
        logic ready;
        if (!rst_n) begin
            model_live = 1'b1;
            m_valid = 1'b0; m_halted = 1'b0; m_ill = 1'b0; m_cnt = 32'd0; m_b = '0;
        end else if (model_live) begin
            ready = !m_halted && (!m_valid || out_ready);
            if (in_valid && ready) begin
                m_b = model_decode(in_inst, in_pc, rs1_data);
                m_valid = 1'b1;
                m_cnt = m_cnt + 32'd1;
                if (m_b.halt) m_halted = 1'b1;
                if (m_b.ill) m_ill = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("out_valid", out_valid, m_valid);
            chk("in_ready", in_ready, !m_halted && (!m_valid || out_ready));
            chk("halted", halted, m_halted);
            chk("halt_illegal", halt_illegal, m_ill);
            chk("dec_count", dec_count, m_cnt);
            chk("rs1_addr", rs1_addr, in_inst[19:15]);
            if (m_valid) begin
                chk("alu_op", alu_op, m_b.op);
                chk("rf_wen", rf_wen, m_b.wen);
                chk("jump_valid", jump_valid, m_b.jv);
                chk("out_pc", out_pc, m_b.pc);
                if (m_b.op != 2'd0) begin
                    chk("alu_src1", alu_src1, m_b.src1);
                    chk("alu_src2", alu_src2, m_b.src2);
                    chk("rd", rd, m_b.rd);
                end
                if (m_b.jv) chk("jump_target", jump_target, m_b.jt);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1);
        in_inst = inst; in_pc = pc; rs1_data = r1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 39);
        case (k)
            0, 1, 2, 3:  return {r[31:12], r[11:7], 7'h37};
            4, 5, 6, 7:  return {r[31:12], r[11:7], 7'h17};
            8, 9, 10, 11: return {r[31:15], 3'd0, r[11:7], 7'h67};
            12: return 32'h00100073;
            13: return {r[31:15], 3'd0, r[11:7], 7'h33};
            14: return {r[31:15], (r[14:12] == 3'd0) ? 3'd2 : r[14:12], r[11:7], 7'h13};
            15: return {r[31:15], (r[14:12] == 3'd0) ? 3'd1 : r[14:12], r[11:7], 7'h67};
            default: return {r[31:15], 3'd0, r[11:7], 7'h13};
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 32'h0; rs1_data = 32'h0;
        cyc(); cyc();
        rst_n = 1'b1;
        chk("rst out_valid", out_valid, 32'd0);
        chk("rst dec_count", dec_count, 32'd0);
        chk("rst in_ready", in_ready, 32'd1);
        chk("rst alu_op", alu_op, 32'd0);
        chk("rst halted", halted, 32'd0);

        out_ready = 1'b1;
        issue(32'hFFF08293, 32'h80000000, 32'h10);
        chk("addi out_valid", out_valid, 32'd1);
        chk("addi alu_op", alu_op, 32'd1);
        chk("addi src1", alu_src1, 32'h10);
        chk("addi src2", alu_src2, 32'hFFFFFFFF);
        chk("addi rd", rd, 32'd5);
        chk("addi rf_wen", rf_wen, 32'd1);

        issue(32'h12345197, 32'h80000000, 32'h0);
        chk("auipc src1", alu_src1, 32'h80000000);
        chk("auipc src2", alu_src2, 32'h12345000);
        chk("auipc alu_op", alu_op, 32'd2);

        do_reset();
        out_ready = 1'b0;
        issue(32'h00700313, 32'h100, 32'h0);
        in_inst = 32'h00900393; in_pc = 32'h104; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall in_ready", in_ready, 32'd0);
            chk("stall rd", rd, 32'd6);
            chk("stall src2", alu_src2, 32'd7);
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("b2b rd", rd, 32'd7);
        chk("b2b dec_count", dec_count, 32'd2);
        chk("b2b out_valid", out_valid, 32'd1);
        cyc();
        chk("drain out_valid", out_valid, 32'd0);

        issue(32'h008100E7, 32'h80000010, 32'h80000101);
        chk("jalr target", jump_target, 32'h80000108);
        chk("jalr src2", alu_src2, 32'd4);
        chk("jalr jump_valid", jump_valid, 32'd1);

        for (int t = 0; t < 2; t++) begin
            do_reset();
            out_ready = 1'b0;
            issue((t == 0) ? 32'h00100073 : 32'hFFFFFFFF, 32'h200, 32'h0);
            chk("halt halted", halted, 32'd1);
            chk("halt in_ready", in_ready, 32'd0);
            chk("halt out_valid", out_valid, 32'd1);
            chk("halt illegal", halt_illegal, t);
            out_ready = 1'b1;
            cyc();
            chk("halt drained", out_valid, 32'd0);
            issue(32'h00500293, 32'h204, 32'h0);
            chk("halt no load", dec_count, 32'd1);
            chk("halt in_ready after", in_ready, 32'd0);
        end

        do_reset();
        out_ready = 1'b0;
        issue(32'h00500293, 32'h300, 32'h0);
        chk("pend out_valid", out_valid, 32'd1);
        do_reset();
        chk("mid-stall rst out_valid", out_valid, 32'd0);
        chk("mid-stall rst dec_count", dec_count, 32'd0);
        out_ready = 1'b1;
        issue(32'h00500013, 32'h304, 32'h0);
        chk("x0 rf_wen", rf_wen, 32'd0);
        chk("x0 rd", rd, 32'd0);
        chk("x0 alu_op", alu_op, 32'd1);

        for (int i = 0; i < 2000; i++) begin
            in_inst   = gen_inst();
            in_pc     = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            rs1_data  = (in_inst[19:15] == 5'd0) ? 32'h0 : $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst_n     = !((m_halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 63) == 0);
            cyc();
        end
        rst_n = 1'b1; in_valid = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
